// File: rtl/fsic_io_serdes_pkg.sv
// rtl/fsic_io_serdes_pkg.sv - shared constants and state encoding for the FSIC IO serdes TX/RX pair
package fsic_io_serdes_pkg;

    localparam int SERDES_CLK_RATIO = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_SEND  = 2'd2
    } serdes_state_e;

endpackage

// File: rtl/fsic_io_serdes_clkgate.sv
// rtl/fsic_io_serdes_clkgate.sv - glitch-free gate for the forwarded serial clock
module fsic_io_serdes_clkgate (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    output logic gclk_o
);

    logic en_q;

    // Enable only moves while clk_i is low, so the AND cannot chop a high phase.
    always_ff @(negedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            en_q <= 1'b0;
        end else begin
            en_q <= en_i;
        end
    end

    assign gclk_o = clk_i & en_q;

endmodule

// File: rtl/fsic_io_serdes_tx.sv
// rtl/fsic_io_serdes_tx.sv - parallel-to-serial transmitter with forwarded gated bit clock
module fsic_io_serdes_tx
    import fsic_io_serdes_pkg::*;
#(
    parameter int pCLK_RATIO = SERDES_CLK_RATIO
) (
    input  logic                  ioclk,
    input  logic                  axis_rst_n,
    input  logic                  txen,
    input  logic [pCLK_RATIO-1:0] txdata_in,
    output logic                  Serial_Data_out,
    output logic                  txclk,
    output logic                  tx_active,
    output logic [15:0]           tx_word_cnt
);

    localparam int PH_W = (pCLK_RATIO > 1) ? $clog2(pCLK_RATIO) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(pCLK_RATIO - 1);

    serdes_state_e         state_q, state_d;
    logic [PH_W-1:0]       phase_q, phase_d;
    logic [pCLK_RATIO-1:0] shift_q, shift_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  serial_q;
    logic                  active_q;
    logic                  word_end;
    logic                  send_next;

    // Phase wrap to 0 coincides with the coreclk rising edge, so the word
    // boundary is always the edge where phase sits at its last value.
    assign word_end  = (phase_q == PH_LAST);
    assign phase_d   = word_end ? '0 : phase_q + PH_W'(1);
    assign send_next = (state_d == ST_SEND);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (txen) begin
                    state_d = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (!txen) begin
                    state_d = ST_IDLE;
                end else if (word_end) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (word_end) begin
                    state_d = txen ? ST_SEND : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        shift_d = shift_q;
        if (word_end && send_next) begin
            shift_d = txdata_in;
        end else if (state_q == ST_SEND) begin
            shift_d = shift_q >> 1;
        end
    end

    assign cnt_d = (word_end && (state_q == ST_SEND)) ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge ioclk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q  <= ST_IDLE;
            phase_q  <= PH_LAST;
            shift_q  <= '0;
            cnt_q    <= '0;
            serial_q <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            serial_q <= send_next ? shift_d[0] : 1'b0;
            active_q <= send_next;
        end
    end

    // The gate samples next-state on the falling edge, so txclk goes high in
    // exactly those cycles whose post-edge state is SEND.
    fsic_io_serdes_clkgate u_clkgate (
        .clk_i   (ioclk),
        .rst_n_i (axis_rst_n),
        .en_i    (send_next),
        .gclk_o  (txclk)
    );

    assign Serial_Data_out = serial_q;
    assign tx_active       = active_q;
    assign tx_word_cnt     = cnt_q;

endmodule

// File: tb/tb_fsic_io_serdes_tx.sv
// tb/tb_fsic_io_serdes_tx.sv - scoreboard bench for fsic_io_serdes_tx with far-end deserializer model
module tb_fsic_io_serdes_tx;

    logic        ioclk = 1'b0;
    logic        axis_rst_n = 1'b0;
    logic        txen = 1'b0;
    logic [3:0]  txdata_in = 4'h0;
    logic        Serial_Data_out;
    logic        txclk;
    logic        tx_active;
    logic [15:0] tx_word_cnt;

    fsic_io_serdes_tx #(.pCLK_RATIO(4)) dut (
        .ioclk           (ioclk),
        .axis_rst_n      (axis_rst_n),
        .txen            (txen),
        .txdata_in       (txdata_in),
        .Serial_Data_out (Serial_Data_out),
        .txclk           (txclk),
        .tx_active       (tx_active),
        .tx_word_cnt     (tx_word_cnt)
    );

    always #5 ioclk = ~ioclk;

    typedef struct {
        logic [3:0] w;
        longint     t;
    } exp_t;

    int         n_pass = 0;
    int         n_total = 0;
    int         ph;
    int         exp_wc = 0;
    int         neg_cnt = 0;
    longint     neg_t[$];
    longint     rise_t = 0;
    exp_t       exp_q[$];
    logic [3:0] bw[$];
    logic [3:0] rx_sr = 4'h0;
    int         rx_bits = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference coreclk phase: last value out of reset, wraps every 4 bit clocks.
    always @(posedge ioclk or negedge axis_rst_n) begin
        if (!axis_rst_n) ph <= 3;
        else ph <= (ph == 3) ? 0 : ph + 1;
    end

    always @(posedge txclk) rise_t = $time;

    // Far-end deserializer: samples on txclk falling edges, LSB first.
    always @(negedge txclk or negedge axis_rst_n) begin
        exp_t e;
        if (!axis_rst_n) begin
            rx_bits = 0;
            rx_sr   = 4'h0;
        end else begin
            neg_cnt++;
            neg_t.push_back($time);
            check("txclk_high_width", $time - rise_t, 5);
            rx_sr = {Serial_Data_out, rx_sr[3:1]};
            rx_bits++;
            if (rx_bits == 4) begin
                rx_bits = 0;
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_word", rx_sr, e.w);
                    check("word_latency", $time - e.t, 34);
                end
            end
        end
    end

    task automatic step();
        @(posedge ioclk);
        #1;
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < 8; i++) begin
            step();
            if (ph == p) return;
        end
        check("wait_phase_timeout", 0, 1);
    endtask

    // Sends bw[0..n-1] back-to-back from IDLE; drop_mid releases txen after bit 1 of the last word.
    task automatic run_burst(input int n, input bit drop_mid);
        int   neg0;
        exp_t e;
        wait_phase(1);
        neg0      = neg_cnt;
        txen      = 1'b1;
        txdata_in = bw[0];
        step();
        step();
        check("align_not_active", tx_active, 0);
        step();
        check("send_at_phase0", tx_active, 1);
        check("send_phase", ph, 0);
        for (int i = 0; i < n; i++) begin
            e.w = bw[i];
            e.t = $time;
            exp_q.push_back(e);
            if (i + 1 < n) txdata_in = bw[i + 1];
            else if (!drop_mid) txen = 1'b0;
            step();
            step();
            if (i + 1 == n && drop_mid) txen = 1'b0;
            step();
            step();
        end
        exp_wc += n;
        check("idle_after_burst", tx_active, 0);
        check("serial_zero_idle", Serial_Data_out, 0);
        check("word_cnt", tx_word_cnt, exp_wc);
        repeat (3) step();
        check("txclk_edges", neg_cnt - neg0, 4 * n);
        if (neg_cnt - neg0 == 4 * n)
            check("txclk_continuous", neg_t[neg0 + 4 * n - 1] - neg_t[neg0], (4 * n - 1) * 10);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bad;
        int sent;
        int n;
        repeat (3) @(posedge ioclk);
        #2;
        check("rst_serial", Serial_Data_out, 0);
        check("rst_txclk", txclk, 0);
        check("rst_active", tx_active, 0);
        check("rst_word_cnt", tx_word_cnt, 0);
        step();
        axis_rst_n = 1'b1;

        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge ioclk);
            #2;
            if (Serial_Data_out !== 1'b0 || txclk !== 1'b0 || tx_active !== 1'b0) bad++;
        end
        check("idle_flat_cycles", bad, 0);
        check("idle_word_cnt", tx_word_cnt, 0);
        check("idle_no_edges", neg_cnt, 0);

        bw = '{4'b1011};
        run_burst(1, 1'b0);

        bw = '{4'hA, 4'h5, 4'hF, 4'h0};
        run_burst(4, 1'b0);

        bw = '{4'h6};
        run_burst(1, 1'b1);

        begin
            int neg0;
            wait_phase(1);
            txen      = 1'b1;
            txdata_in = 4'h9;
            repeat (3) step();
            step();
            step();
            #5;
            neg0       = neg_cnt;
            axis_rst_n = 1'b0;
            txen       = 1'b0;
            #1;
            check("arst_serial", Serial_Data_out, 0);
            check("arst_active", tx_active, 0);
            check("arst_word_cnt", tx_word_cnt, 0);
            #5;
            check("arst_txclk", txclk, 0);
            exp_wc = 0;
            repeat (4) step();
            check("arst_no_edges", neg_cnt - neg0, 0);
            axis_rst_n = 1'b1;
            bw = '{4'h3};
            run_burst(1, 1'b0);
        end

        sent = 0;
        while (sent < 64) begin
            n = $urandom_range(1, 8);
            if (sent + n > 64) n = 64 - sent;
            bw.delete();
            for (int i = 0; i < n; i++) bw.push_back(4'($urandom_range(0, 15)));
            run_burst(n, 1'($urandom_range(0, 1)));
            sent += n;
        end

        repeat (4) step();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fsic_io_serdes_tx.md
FSIC_IO_SERDES_TX -- requirements
Module: fsic_io_serdes_tx

Interface
REQ-001 SHALL have parameter pCLK_RATIO, default 4, meaning serial bits per parallel word and ioclk cycles per coreclk cycle.
REQ-002 SHALL have input ioclk, 1 bit: the serial bit clock; all state updates on its rising edge except REQ-016.
REQ-003 SHALL have input axis_rst_n, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have input txen, 1 bit, synchronous to ioclk: transmit enable.
REQ-005 SHALL have input txdata_in, pCLK_RATIO bits: parallel word launched from coreclk, stable for pCLK_RATIO ioclk cycles.
REQ-006 SHALL have output Serial_Data_out, 1 bit: serial data, LSB first.
REQ-007 SHALL have output txclk, 1 bit: forwarded, gated copy of ioclk; the far-end deserializer samples on its falling edge.
REQ-008 SHALL have output tx_active, 1 bit: high while state is SEND.
REQ-009 SHALL have output tx_word_cnt, 16 bits: count of words fully transmitted.

Function
REQ-010 SHALL keep a free-running phase counter of width clog2(pCLK_RATIO): resets to pCLK_RATIO-1, +1 every ioclk, wraps pCLK_RATIO-1 -> 0 regardless of txen; wrap to 0 coincides with coreclk rising.
REQ-011 SHALL implement states IDLE, ALIGN, SEND; reset state IDLE.
REQ-012 IDLE -> ALIGN when txen=1; ALIGN -> IDLE when txen=0; ALIGN -> SEND at the edge where phase==pCLK_RATIO-1 and txen=1.
REQ-013 On every edge with phase==pCLK_RATIO-1 whose next state is SEND, SHALL load the shift register from txdata_in (pre-edge value); otherwise in SEND shift right by one, MSB filled 0.
REQ-014 Serial_Data_out SHALL equal shift_reg[0] while in SEND and 0 otherwise: bit k of a word is driven during the k-th ioclk cycle after its load edge (latency 0 cycles to bit 0, word spans pCLK_RATIO cycles).
REQ-015 In SEND at a phase==pCLK_RATIO-1 edge: txen=1 -> stay SEND and reload (back-to-back, no gap cycle); txen=0 -> IDLE; txen deassertion mid-word SHALL NOT truncate the word.
REQ-016 txclk SHALL be high exactly during the high half of every ioclk cycle whose post-edge state is SEND, low otherwise; enable register updated on ioclk falling edge from next-state; no glitches or runt pulses.
REQ-017 Exactly pCLK_RATIO txclk falling edges SHALL occur per transmitted word, each in the middle of its bit period.
REQ-018 tx_word_cnt SHALL increment by 1 at every phase==pCLK_RATIO-1 edge leaving a SEND word-end, wrapping 0xFFFF -> 0x0000.
REQ-019 tx_active SHALL be registered and equal (state==SEND).

Reset
REQ-020 Asserting axis_rst_n low SHALL immediately force: state IDLE, phase pCLK_RATIO-1, shift register 0, Serial_Data_out 0, txclk 0 (enable cleared), tx_active 0, tx_word_cnt 0.
REQ-021 Reset mid-word SHALL abort the word with no further txclk edges; after release the block re-enters via IDLE/ALIGN.

Structure
REQ-022 State encoding constants and the default pCLK_RATIO SHALL reside in the shared package fsic_io_serdes_pkg, used also by the RX side.
REQ-023 Clock gating SHALL be a sub-module fsic_io_serdes_clkgate (negedge-enable register plus AND); everything else flat.

Verification
REQ-024 Reset, txen=0 for 20 cycles -> Serial_Data_out=0, txclk flat 0, tx_active=0, tx_word_cnt=0.
REQ-025 txen=1 at phase 1, txdata_in=4'b1011 -> SEND entered at next phase-3 edge; serial 1,1,0,1; exactly 4 txclk falling edges; tx_word_cnt=1.
REQ-026 Words 0xA,0x5,0xF,0x0 back-to-back with txen held -> serial 0101 1010 1111 0000, no gap cycle, txclk continuous for 16 cycles, tx_word_cnt=4.
REQ-027 txen dropped after bit 1 of word 0x6 -> bits 0,1,1,0 complete, then IDLE; txclk stops with no runt pulse; tx_word_cnt +1.
REQ-028 axis_rst_n pulsed low during bit 2 -> outputs zero asynchronously, tx_word_cnt=0; after release and txen=1, next word sent aligned to phase 0.
REQ-029 Loopback into fsic_io_serdes_rx (rxclk=txclk, rxen=tx_active), 64 random words -> rxdata_out matches transmitted sequence in order with constant latency.
